// File: rtl/video_ts_task_queue_pkg.sv
// Shared types for the TS render-task queue: field widths and the packed 40-bit task entry.
package video_ts_pkg;

    localparam int unsigned X_COORD_W = 9;
    localparam int unsigned X_SIZE_W  = 3;
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned LINE_W    = 9;
    localparam int unsigned PAGE_W    = 8;
    localparam int unsigned PAL_W     = 4;
    localparam int unsigned TASK_W    = 40;

    // Packed MSB-first: x_coord[39:31] .. pal[3:0]
    typedef struct packed {
        logic [X_COORD_W-1:0] x_coord;
        logic [X_SIZE_W-1:0]  x_size;
        logic                 flip;
        logic [ADDR_W-1:0]    addr;
        logic [LINE_W-1:0]    line;
        logic [PAGE_W-1:0]    page;
        logic [PAL_W-1:0]     pal;
    } ts_task_t;

endpackage

// File: rtl/video_ts_task_queue_if.sv
// Parser/renderer-facing bundle of the TS task queue; slave is the queue, master the surroundings.
interface video_ts_task_queue_if
    import video_ts_pkg::*;
#(
    parameter int unsigned AW = 2
) ();

    logic                 flush;
    logic                 enable;
    logic                 task_valid;
    logic                 task_ready;
    logic [X_COORD_W-1:0] task_x_coord;
    logic [X_SIZE_W-1:0]  task_x_size;
    logic                 task_flip;
    logic [ADDR_W-1:0]    task_addr;
    logic [LINE_W-1:0]    task_line;
    logic [PAGE_W-1:0]    task_page;
    logic [PAL_W-1:0]     task_pal;
    logic                 mem_rdy;
    logic                 tsr_go;
    logic [X_COORD_W-1:0] x_coord;
    logic [X_SIZE_W-1:0]  x_size;
    logic                 flip;
    logic [ADDR_W-1:0]    addr;
    logic [LINE_W-1:0]    line;
    logic [PAGE_W-1:0]    page;
    logic [PAL_W-1:0]     pal;
    logic [AW:0]          level;
    logic                 line_done;
    logic [7:0]           issued_cnt;

    modport slave (
        input  flush, enable, task_valid, task_x_coord, task_x_size, task_flip,
               task_addr, task_line, task_page, task_pal, mem_rdy,
        output task_ready, tsr_go, x_coord, x_size, flip, addr, line, page, pal,
               level, line_done, issued_cnt
    );

    modport master (
        output flush, enable, task_valid, task_x_coord, task_x_size, task_flip,
               task_addr, task_line, task_page, task_pal, mem_rdy,
        input  task_ready, tsr_go, x_coord, x_size, flip, addr, line, page, pal,
               level, line_done, issued_cnt
    );

endinterface

// File: rtl/video_ts_task_fifo.sv
// Synchronous FIFO with flush; head entry is read combinationally, no fall-through.
module video_ts_task_fifo
    import video_ts_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned W     = TASK_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata_c,
    output logic [AW:0]   count,
    output logic          full_c,
    output logic          empty_c
);

    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_push;
    logic          do_pop;

    // A full FIFO refuses a push even when a pop frees a slot in the same cycle
    always_comb begin
        full_c  = (count == CW'(DEPTH));
        empty_c = (count == '0);
        do_push = push && !full_c;
        do_pop  = pop && !empty_c;
        rdata_c = mem[rp];
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop)  rp <= rp + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) mem[wp] <= wdata;
    end

endmodule

// File: rtl/video_ts_task_queue.sv
// TS render-task buffer: queues parser tasks and launches one per renderer ready point.
module video_ts_task_queue
    import video_ts_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    video_ts_task_queue_if.slave    bus
);

    ts_task_t          wr_task;
    ts_task_t          head;
    logic [TASK_W-1:0] head_bits;
    logic [AW:0]       count;
    logic              full_c;
    logic              empty_c;
    logic              ready_c;
    logic              go_c;
    logic [7:0]        issued_q;

    always_comb begin
        wr_task = '{x_coord: bus.task_x_coord, x_size: bus.task_x_size, flip: bus.task_flip,
                    addr: bus.task_addr, line: bus.task_line, page: bus.task_page,
                    pal: bus.task_pal};
        head    = ts_task_t'(head_bits);
        ready_c = !full_c && !bus.flush && !reset;
        // Straight from mem_rdy so the renderer can chain the next task at its ready point
        go_c    = bus.enable && bus.mem_rdy && !empty_c && !bus.flush && !reset;
    end

    video_ts_task_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (TASK_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (bus.flush),
        .push    (bus.task_valid && ready_c),
        .pop     (go_c),
        .wdata   (TASK_W'(wr_task)),
        .rdata_c (head_bits),
        .count   (count),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    always_ff @(posedge clk) begin
        if (reset || bus.flush)           issued_q <= '0;
        else if (go_c && issued_q != 8'hFF) issued_q <= issued_q + 8'd1;
    end

    assign bus.task_ready = ready_c;
    assign bus.tsr_go     = go_c;
    assign bus.x_coord    = head.x_coord;
    assign bus.x_size     = head.x_size;
    assign bus.flip       = head.flip;
    assign bus.addr       = head.addr;
    assign bus.line       = head.line;
    assign bus.page       = head.page;
    assign bus.pal        = head.pal;
    assign bus.level      = count;
    assign bus.line_done  = empty_c && bus.mem_rdy && !go_c;
    assign bus.issued_cnt = issued_q;

endmodule

// File: tb/tb_video_ts_task_queue.sv
// Bench for video_ts_task_queue: directed table, corner sequences and random traffic vs a queue model.
module tb_video_ts_task_queue;
    import video_ts_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    video_ts_task_queue_if #(.AW(AW)) bus ();

    video_ts_task_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an ordered list of pending tasks plus a saturating launch count
    ts_task_t mq[$];
    int       m_iss;

    typedef struct {
        logic     fl, en, v, mr;
        ts_task_t t;
        logic     e_ready, e_go, e_done;
        int       e_level, e_iss;
        ts_task_t e_head;
    } vec_t;

    vec_t vec[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ts_task_t dut_head();
        return '{x_coord: bus.x_coord, x_size: bus.x_size, flip: bus.flip, addr: bus.addr,
                 line: bus.line, page: bus.page, pal: bus.pal};
    endfunction

    function automatic ts_task_t rand_task();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return ts_task_t'(r[39:0]);
    endfunction

    function automatic vec_t mk(input logic fl, en, v, mr, input ts_task_t t,
                                input logic er, eg, ed, input int lvl, iss, input ts_task_t hd);
        vec_t x;
        x.fl = fl; x.en = en; x.v = v; x.mr = mr; x.t = t;
        x.e_ready = er; x.e_go = eg; x.e_done = ed; x.e_level = lvl; x.e_iss = iss; x.e_head = hd;
        return x;
    endfunction

    // Drive inputs shortly after an edge and let combinational outputs settle
    task automatic apply(input logic fl, en, v, mr, input ts_task_t t);
        bus.flush        = fl;
        bus.enable       = en;
        bus.task_valid   = v;
        bus.mem_rdy      = mr;
        bus.task_x_coord = t.x_coord;
        bus.task_x_size  = t.x_size;
        bus.task_flip    = t.flip;
        bus.task_addr    = t.addr;
        bus.task_line    = t.line;
        bus.task_page    = t.page;
        bus.task_pal     = t.pal;
        #2;
    endtask

    function automatic logic m_ready();
        return (mq.size() < DEPTH) && !bus.flush;
    endfunction

    function automatic logic m_go();
        return bus.enable && bus.mem_rdy && (mq.size() != 0) && !bus.flush;
    endfunction

    task automatic check_model(input string tag);
        logic eg;
        eg = m_go();
        chk({tag, "_ready"}, 64'(bus.task_ready), 64'(m_ready()));
        chk({tag, "_go"}, 64'(bus.tsr_go), 64'(eg));
        chk({tag, "_level"}, 64'(bus.level), 64'(mq.size()));
        chk({tag, "_done"}, 64'(bus.line_done), 64'((mq.size() == 0) && bus.mem_rdy && !eg));
        chk({tag, "_issued"}, 64'(bus.issued_cnt), 64'(m_iss));
        if (eg) chk({tag, "_head"}, 64'(dut_head()), 64'(mq[0]));
    endtask

    // Clock edge plus model update; acc reports whether the offered task was taken
    task automatic advance(output logic acc);
        logic     fl, er, eg, v;
        ts_task_t t;
        fl = bus.flush; er = m_ready(); eg = m_go(); v = bus.task_valid;
        t = '{x_coord: bus.task_x_coord, x_size: bus.task_x_size, flip: bus.task_flip,
              addr: bus.task_addr, line: bus.task_line, page: bus.task_page, pal: bus.task_pal};
        acc = v && er;
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_iss = 0;
        end else begin
            if (eg) begin
                void'(mq.pop_front());
                if (m_iss < 255) m_iss++;
            end
            if (acc) mq.push_back(t);
        end
        #1;
    endtask

    task automatic cycle(input string tag, input logic fl, en, v, mr, input ts_task_t t,
                         output logic acc);
        apply(fl, en, v, mr, t);
        check_model(tag);
        advance(acc);
    endtask

    initial begin
        ts_task_t a, b, c, d, z, t;
        ts_task_t pend[$];
        ts_task_t sent[$];
        ts_task_t got[$];
        logic     acc, mr, prev_go;
        int       launches;

        a = '{x_coord: 9'h010, x_size: 3'd1, flip: 1'b0, addr: 6'd3, line: 9'd5, page: 8'h20, pal: 4'd7};
        b = '{x_coord: 9'h1A5, x_size: 3'd7, flip: 1'b1, addr: 6'd63, line: 9'h100, page: 8'hFF, pal: 4'd1};
        c = '{x_coord: 9'h0C3, x_size: 3'd2, flip: 1'b0, addr: 6'd21, line: 9'h0AA, page: 8'h5A, pal: 4'd12};
        d = '{x_coord: 9'h1FF, x_size: 3'd0, flip: 1'b1, addr: 6'd0, line: 9'h1FF, page: 8'h01, pal: 4'd15};
        z = '0;

        vec[0]  = mk(0, 1, 1, 1, a, 1, 0, 1, 0, 0, z);
        vec[1]  = mk(0, 1, 0, 1, z, 1, 1, 0, 1, 0, a);
        vec[2]  = mk(0, 1, 0, 0, z, 1, 0, 0, 0, 1, z);
        vec[3]  = mk(0, 1, 0, 1, z, 1, 0, 1, 0, 1, z);
        vec[4]  = mk(0, 1, 1, 0, b, 1, 0, 0, 0, 1, z);
        vec[5]  = mk(0, 1, 1, 0, c, 1, 0, 0, 1, 1, z);
        vec[6]  = mk(0, 1, 1, 0, d, 1, 0, 0, 2, 1, z);
        vec[7]  = mk(1, 1, 1, 1, a, 0, 0, 0, 3, 1, z);
        vec[8]  = mk(0, 1, 0, 1, z, 1, 0, 1, 0, 0, z);
        vec[9]  = mk(0, 0, 1, 0, b, 1, 0, 0, 0, 0, z);
        vec[10] = mk(0, 0, 1, 0, c, 1, 0, 0, 1, 0, z);
        vec[11] = mk(0, 0, 0, 1, z, 1, 0, 0, 2, 0, z);
        vec[12] = mk(0, 0, 0, 1, z, 1, 0, 0, 2, 0, z);
        vec[13] = mk(0, 1, 0, 1, z, 1, 1, 0, 2, 0, b);
        vec[14] = mk(0, 1, 0, 0, z, 1, 0, 0, 1, 1, z);
        vec[15] = mk(0, 1, 0, 1, z, 1, 1, 0, 1, 1, c);
        vec[16] = mk(0, 1, 0, 0, z, 1, 0, 0, 0, 2, z);
        vec[17] = mk(0, 1, 0, 1, z, 1, 0, 1, 0, 2, z);

        // Reset behaviour
        reset = 1'b1;
        apply(0, 1, 1, 1, a);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(bus.task_ready), 64'(0));
        chk("rst_go", 64'(bus.tsr_go), 64'(0));
        chk("rst_level", 64'(bus.level), 64'(0));
        chk("rst_issued", 64'(bus.issued_cnt), 64'(0));
        chk("rst_done_hi", 64'(bus.line_done), 64'(1));
        apply(0, 1, 0, 0, z);
        chk("rst_done_lo", 64'(bus.line_done), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        m_iss = 0;

        // Directed table: first launch latency, flush with pending tasks, enable gating
        foreach (vec[i]) begin
            apply(vec[i].fl, vec[i].en, vec[i].v, vec[i].mr, vec[i].t);
            chk($sformatf("tbl%0d_ready", i), 64'(bus.task_ready), 64'(vec[i].e_ready));
            chk($sformatf("tbl%0d_go", i), 64'(bus.tsr_go), 64'(vec[i].e_go));
            chk($sformatf("tbl%0d_level", i), 64'(bus.level), 64'(vec[i].e_level));
            chk($sformatf("tbl%0d_done", i), 64'(bus.line_done), 64'(vec[i].e_done));
            chk($sformatf("tbl%0d_issued", i), 64'(bus.issued_cnt), 64'(vec[i].e_iss));
            if (vec[i].e_go) chk($sformatf("tbl%0d_head", i), 64'(dut_head()), 64'(vec[i].e_head));
            advance(acc);
        end

        // Full queue with a fifth task held upstream, drained by mem_rdy pulses
        cycle("full_fl", 1, 1, 0, 0, z, acc);
        for (int i = 0; i < 5; i++) pend.push_back(rand_task());
        launches = 0;
        for (int i = 0; i < 20; i++) begin
            mr = (i >= 5) && (i % 2 == 1);
            t  = (pend.size() != 0) ? pend[0] : z;
            apply(0, 1, pend.size() != 0, mr, t);
            if (i == 4) begin
                chk("full_level4", 64'(bus.level), 64'(4));
                chk("full_ready0", 64'(bus.task_ready), 64'(0));
            end
            if (i == 5) chk("full_no_push_on_pop", 64'(bus.task_ready), 64'(0));
            if (bus.tsr_go === 1'b1) launches++;
            check_model("full");
            advance(acc);
            if (acc) void'(pend.pop_front());
        end
        chk("full_launches", 64'(launches), 64'(5));
        chk("full_level_end", 64'(bus.level), 64'(0));

        // Simultaneous push and pop at level 2, ten tasks wrapping the pointers
        cycle("wrap_fl", 1, 1, 0, 0, z, acc);
        pend.delete();
        sent.delete();
        got.delete();
        for (int i = 0; i < 10; i++) begin
            t = rand_task();
            pend.push_back(t);
            sent.push_back(t);
        end
        for (int i = 0; i < 30; i++) begin
            mr = (i >= 2) && (i % 2 == 0);
            t  = (pend.size() != 0) ? pend[0] : z;
            apply(0, 1, pend.size() != 0, mr, t);
            if (i == 3) chk("wrap_level_hold", 64'(bus.level), 64'(2));
            if (bus.tsr_go === 1'b1) got.push_back(dut_head());
            check_model("wrap");
            advance(acc);
            if (acc) void'(pend.pop_front());
        end
        chk("wrap_count", 64'(got.size()), 64'(10));
        for (int i = 0; i < 10 && i < got.size(); i++)
            chk($sformatf("wrap_order%0d", i), 64'(got[i]), 64'(sent[i]));

        // issued_cnt saturation over 300 launches
        cycle("sat_fl", 1, 1, 0, 0, z, acc);
        for (int i = 0; i < 300; i++) begin
            cycle("sat_push", 0, 1, 1, 0, rand_task(), acc);
            cycle("sat_go", 0, 1, 0, 1, z, acc);
        end
        chk("sat_issued", 64'(bus.issued_cnt), 64'(255));

        // Random traffic; mem_rdy drops the cycle after a launch like the renderer does
        prev_go = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            mr = !prev_go && ($urandom_range(0, 3) != 0);
            apply($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 1) == 1, mr, rand_task());
            prev_go = m_go();
            check_model("rnd");
            advance(acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
